serial_rx_arbiter: RTL and testbench

- Merges the byte streams of NCH serial byte receivers onto one shared downstream byte sink.
- Each receiver delivers a byte with a single-cycle done pulse. This block buffers one byte per channel, picks a buffered channel round-robin and presents the byte on a valid/ready output tagged with its channel number.
- Sits between the receiver bank and the shared protocol/packet FIFO.

---
 rtl/serial_rx_arbiter.sv | 124 ++++++++++++
 tb/tb_serial_rx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_arbiter.sv
// Merges NCH single-byte serial receiver streams onto one valid/ready byte sink.
// One holding buffer per channel with round-robin grant into a registered output stage.
module serial_rx_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*8-1:0]  rx_byte,
    input  logic [NCH-1:0]    rx_done,
    input  logic [NCH-1:0]    chan_en,
    output logic [7:0]        out_byte,
    output logic [CW-1:0]     out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH-1:0]    ovf,
    input  logic [NCH-1:0]    ovf_clr
);

    logic [7:0]     hold_byte_r [NCH];
    logic [NCH-1:0] full_r;
    logic [CW-1:0]  rr_r;

    logic           load_slot_s;
    logic           found_s;
    logic [CW-1:0]  grant_s;
    logic [CW-1:0]  rr_next_s;
    logic [CW:0]    idx_s;
    logic [NCH-1:0] move_s;
    logic [NCH-1:0] cap_s;
    logic [NCH-1:0] ovf_set_s;

    // Round-robin search: first full buffer at or after rr, wrapping at NCH.
    always_comb begin
        found_s = 1'b0;
        grant_s = {CW{1'b0}};
        idx_s   = {(CW+1){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            idx_s = {1'b0, rr_r} + (CW+1)'(k);
            if (idx_s >= (CW+1)'(NCH)) begin
                idx_s = idx_s - (CW+1)'(NCH);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && full_r[idx_s[CW-1:0]]) begin
                found_s = 1'b1;
                grant_s = idx_s[CW-1:0];
            end else begin
                found_s = found_s;
                grant_s = grant_s;
            end
        end
    end

    // Pointer advance past the granted channel.
    always_comb begin
        if (grant_s == CW'(NCH - 1)) begin
            rr_next_s = {CW{1'b0}};
        end else begin
            rr_next_s = grant_s + CW'(1);
        end
    end

    // Per-channel move/capture/overflow decode; a moving buffer can be refilled on the same edge.
    always_comb begin
        load_slot_s = !out_valid || out_ready;
        move_s      = {NCH{1'b0}};
        cap_s       = {NCH{1'b0}};
        ovf_set_s   = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            move_s[i]    = load_slot_s && found_s && (grant_s == CW'(i));
            cap_s[i]     = rx_done[i] && chan_en[i];
            ovf_set_s[i] = cap_s[i] && full_r[i] && !move_s[i];
        end
    end

    // Holding buffers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                hold_byte_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap_s[i] && (!full_r[i] || move_s[i])) begin
                    hold_byte_r[i] <= rx_byte[8*i +: 8];
                    full_r[i]      <= 1'b1;
                end else if (move_s[i]) begin
                    full_r[i] <= 1'b0;
                end
            end
        end
    end

    // Output register and arbitration pointer; stalled while valid and not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_byte  <= 8'h00;
            out_chan  <= {CW{1'b0}};
            out_valid <= 1'b0;
            rr_r      <= {CW{1'b0}};
        end else if (load_slot_s) begin
            if (found_s) begin
                out_byte  <= hold_byte_r[grant_s];
                out_chan  <= grant_s;
                out_valid <= 1'b1;
                rr_r      <= rr_next_s;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow flags; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= {NCH{1'b0}};
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set_s;
        end
    end

endmodule

// File: tb/tb_serial_rx_arbiter.sv
// Table-driven bench for serial_rx_arbiter with a beat scoreboard on the output handshake.
module tb_serial_rx_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] rx_byte;
    logic [3:0]  rx_done;
    logic [3:0]  chan_en;
    logic [7:0]  out_byte;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ovf;
    logic [3:0]  ovf_clr;

    int n_checks = 0;
    int n_err    = 0;

    logic [9:0] sb_q [$];
    logic [9:0] sb_exp;

    typedef struct {
        logic [3:0]  done;
        logic [31:0] bytes;
        logic [3:0]  en;
        logic        rdy;
        logic [3:0]  clr;
        logic [3:0]  push;
        logic        ev;
        logic [7:0]  eb;
        logic [1:0]  ec;
        logic [3:0]  eovf;
    } vec_t;

    vec_t vecs [$];

    serial_rx_arbiter #(.NCH(4), .CW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_done   (rx_done),
        .chan_en   (chan_en),
        .out_byte  (out_byte),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] done, input logic [31:0] bytes, input logic [3:0] en,
                           input logic rdy, input logic [3:0] clr, input logic [3:0] push,
                           input logic ev, input logic [7:0] eb, input logic [1:0] ec,
                           input logic [3:0] eovf);
        vec_t v;
        v.done = done; v.bytes = bytes; v.en = en; v.rdy = rdy; v.clr = clr;
        v.push = push; v.ev = ev; v.eb = eb; v.ec = ec; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [7:0] b);
        sb_q.push_back({ch, b});
    endtask

    // Scoreboard: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got chan %0d byte %0h, expected no beat", out_chan, out_byte);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_beat", 32'({out_chan, out_byte}), 32'(sb_exp));
            end
        end
    end

    initial begin
        int seen3;
        int beats;
        logic [31:0] b;

        reset     = 1'b0;
        rx_byte   = 32'h0;
        rx_done   = 4'h0;
        chan_en   = 4'hF;
        out_ready = 1'b1;
        ovf_clr   = 4'h0;

        // done, bytes, en, rdy, clr, push, ev, eb, ec, eovf
        // single byte on ch2
        add_vec(4'b0100, 32'h00A50000, 4'hF, 1'b1, 4'h0, 4'b0100, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'hA5, 2'd2, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // ch3 byte to bring rr back to 0
        add_vec(4'b1000, 32'h33000000, 4'hF, 1'b1, 4'h0, 4'b1000, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h33, 2'd3, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // simultaneous arrival on all four channels
        add_vec(4'b1111, 32'h13121110, 4'hF, 1'b1, 4'h0, 4'b1111, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h10, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h11, 2'd1, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h12, 2'd2, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h13, 2'd3, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // backpressure and overflow on ch1
        add_vec(4'b0010, 32'h00005500, 4'hF, 1'b0, 4'h0, 4'b0010, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0010, 32'h00006600, 4'hF, 1'b0, 4'h0, 4'b0010, 1'b1, 8'h55, 2'd1, 4'h0);
        add_vec(4'b0010, 32'h00007700, 4'hF, 1'b0, 4'h0, 4'b0000, 1'b1, 8'h55, 2'd1, 4'b0010);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b0, 4'h0, 4'b0000, 1'b1, 8'h55, 2'd1, 4'b0010);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'h66, 2'd1, 4'b0010);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'b0010);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // drain and refill ch0 on the same edge
        add_vec(4'b0001, 32'h000000A0, 4'hF, 1'b1, 4'h0, 4'b0001, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0001, 32'h000000A1, 4'hF, 1'b1, 4'h0, 4'b0001, 1'b1, 8'hA0, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b1, 8'hA1, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // disabled channel ignores rx_done
        add_vec(4'b0001, 32'h000000EE, 4'b1110, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);
        // buffered byte survives chan_en being cleared
        add_vec(4'b0100, 32'h00D20000, 4'hF, 1'b0, 4'h0, 4'b0100, 1'b0, 8'h00, 2'd0, 4'h0);
        add_vec(4'b0000, 32'h0,        4'h0, 1'b0, 4'h0, 4'b0000, 1'b1, 8'hD2, 2'd2, 4'h0);
        add_vec(4'b0000, 32'h0,        4'h0, 1'b1, 4'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 4'h0);

        #2;
        chk("rst_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_byte",  32'(out_byte),  32'(8'h00));
        chk("rst_chan",  32'(out_chan),  32'(2'd0));
        chk("rst_ovf",   32'(ovf),       32'(4'h0));
        step();
        step();
        reset = 1'b1;

        foreach (vecs[n]) begin
            rx_done   = vecs[n].done;
            rx_byte   = vecs[n].bytes;
            chan_en   = vecs[n].en;
            out_ready = vecs[n].rdy;
            ovf_clr   = vecs[n].clr;
            for (int i = 0; i < 4; i++) begin
                if (vecs[n].push[i]) push_exp(2'(i), vecs[n].bytes[8*i +: 8]);
            end
            step();
            chk($sformatf("v%0d_valid", n), 32'(out_valid), 32'(vecs[n].ev));
            if (vecs[n].ev) begin
                chk($sformatf("v%0d_byte", n), 32'(out_byte), 32'(vecs[n].eb));
                chk($sformatf("v%0d_chan", n), 32'(out_chan), 32'(vecs[n].ec));
            end
            chk($sformatf("v%0d_ovf", n), 32'(ovf), 32'(vecs[n].eovf));
        end

        // Fairness: ch0 refilled every cycle, one ch3 pulse; ch0 byte C3 is dropped.
        rx_done = 4'h0; chan_en = 4'hF; out_ready = 1'b1; ovf_clr = 4'h0;
        push_exp(2'd0, 8'hC0); push_exp(2'd0, 8'hC1); push_exp(2'd3, 8'h3C);
        push_exp(2'd0, 8'hC2); push_exp(2'd0, 8'hC4); push_exp(2'd0, 8'hC5);
        push_exp(2'd0, 8'hC6); push_exp(2'd0, 8'hC7);
        seen3 = -1;
        beats = 0;
        for (int k = 0; k < 12; k++) begin
            b = {24'h0, 8'hC0 + 8'(k)};
            rx_done = (k < 8) ? 4'b0001 : 4'b0000;
            if (k == 2) begin
                rx_done = rx_done | 4'b1000;
                b = b | 32'h3C000000;
            end
            rx_byte = b;
            step();
            if (k > 2 && out_valid) begin
                beats++;
                if (out_chan == 2'd3 && seen3 < 0) seen3 = beats;
            end
        end
        rx_done = 4'h0;
        chk("fair_ch3_within_4", 32'((seen3 >= 1) && (seen3 <= 4)), 32'(1'b1));
        chk("fair_ovf0", 32'(ovf), 32'(4'b0001));
        ovf_clr = 4'b0001;
        step();
        ovf_clr = 4'h0;
        chk("fair_ovf_clr", 32'(ovf), 32'(4'h0));

        // Async reset mid-stream with a stalled output and an overflow pending.
        out_ready = 1'b0;
        rx_done = 4'b0011; rx_byte = 32'h0000E1E0;
        step();
        rx_done = 4'b0001; rx_byte = 32'h000000E2;
        step();
        rx_done = 4'h0;
        chk("pre_rst_valid", 32'(out_valid), 32'(1'b1));
        chk("pre_rst_ovf", 32'(ovf), 32'(4'b0001));
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'(1'b0));
        chk("arst_ovf",   32'(ovf),       32'(4'h0));
        chk("arst_byte",  32'(out_byte),  32'(8'h00));
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        rx_done = 4'b0010; rx_byte = 32'h0000B100;
        push_exp(2'd1, 8'hB1);
        step();
        rx_done = 4'h0;
        chk("post_rst_idle", 32'(out_valid), 32'(1'b0));
        step();
        chk("post_rst_valid", 32'(out_valid), 32'(1'b1));
        chk("post_rst_byte",  32'(out_byte),  32'(8'hB1));
        chk("post_rst_chan",  32'(out_chan),  32'(2'd1));
        step();
        chk("post_rst_done", 32'(out_valid), 32'(1'b0));
        step();
        chk("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
